// File: rtl/spi_master.sv
// SPI master, mode 0 (CPOL=0, CPHA=0), 8-bit transfers, MSB first.
// Register-style interface: spi_start is the output-register write strobe,
// spi_rx_data is the status/data input register
// ([7:0] rx byte, [8] busy, [9] done, [10] overrun).
// Build option: define SPI_LOOPBACK_EN to sample the internal mosi instead
// of the miso pin.
module spi_master #(
  parameter int DIV_W = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        spi_start,
  input  logic [31:0] spi_tx_data,
  input  logic [31:0] spi_clkdiv,
  output logic [31:0] spi_rx_data,
  output logic        sclk,
  output logic        mosi,
  input  logic        miso,
  output logic        cs_n
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SHIFT = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [DIV_W-1:0] r_div;
  logic [DIV_W-1:0] r_cnt;
  logic [3:0]       r_half;
  logic [7:0]       r_tx;
  logic [7:0]       r_rx_sh;
  logic [7:0]       r_rx;
  logic             r_done;
  logic             r_ovr;

  logic             w_busy;
  logic             w_tick;
  logic             w_accept;
  logic             w_rise;
  logic             w_fall_shift;
  logic             w_in;
  logic             w_unused;

  assign w_busy   = (r_state != IDLE);
  assign w_tick   = (r_cnt == r_div);
  assign w_accept = spi_start && (r_state == IDLE);

  // Even halves of SHIFT are SCLK-high. A rising edge starts each even half:
  // end of SETUP, or end of an odd half other than the final one.
  assign w_rise = w_tick && ((r_state == SETUP) ||
                  ((r_state == SHIFT) && r_half[0] && (r_half != 4'd15)));
  // Falling edges end each even half; the last one (end of half 14) leaves
  // bit 0 on mosi through the final low half.
  assign w_fall_shift = w_tick && (r_state == SHIFT) && !r_half[0] &&
                        (r_half != 4'd14);

`ifdef SPI_LOOPBACK_EN
  assign w_in     = r_tx[7];
  assign w_unused = &{1'b0, miso, spi_tx_data[31:8], spi_clkdiv[31:DIV_W]};
`else
  assign w_in     = miso;
  assign w_unused = &{1'b0, spi_tx_data[31:8], spi_clkdiv[31:DIV_W]};
`endif

  assign cs_n        = !w_busy;
  assign sclk        = (r_state == SHIFT) && !r_half[0];
  assign mosi        = w_busy && r_tx[7];
  assign spi_rx_data = {21'd0, r_ovr, r_done, w_busy, r_rx};

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next-state: each non-idle phase ends on a divider tick.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:  if (spi_start) w_next = SETUP;
      SETUP: if (w_tick) w_next = SHIFT;
      SHIFT: if (w_tick && (r_half == 4'd15)) w_next = HOLD;
      HOLD:  if (w_tick) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Datapath: divider, half counter, shift registers and status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_div   <= '0;
      r_cnt   <= '0;
      r_half  <= '0;
      r_tx    <= '0;
      r_rx_sh <= '0;
      r_rx    <= '0;
      r_done  <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      if (!w_busy || w_tick) r_cnt <= '0;
      else                   r_cnt <= r_cnt + 1'b1;

      if (r_state != SHIFT) r_half <= '0;
      else if (w_tick)      r_half <= r_half + 4'd1;

      if (w_accept) begin
        r_tx   <= spi_tx_data[7:0];
        r_div  <= spi_clkdiv[DIV_W-1:0];
        r_done <= 1'b0;
        r_ovr  <= 1'b0;
      end else if (w_fall_shift) begin
        r_tx <= {r_tx[6:0], 1'b0};
      end

      if (spi_start && w_busy) r_ovr <= 1'b1;

      if (w_rise) r_rx_sh <= {r_rx_sh[6:0], w_in};

      if ((r_state == HOLD) && w_tick) begin
        r_rx   <= r_rx_sh;
        r_done <= 1'b1;
      end
    end
  end

endmodule

// File: doc/spi_master.md
SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 Parameter DIV_W, default 16, SHALL set the number of low bits of spi_clkdiv used as the divider.
REQ-002 clk  input  1  SHALL be the single system clock; all state changes on its rising edge.
REQ-003 rst  input  1  SHALL be the synchronous, active-high reset.
REQ-004 spi_start  input  1  SHALL be a one-cycle request: write strobe of the SPI output register.
REQ-005 spi_tx_data  input  32  SHALL carry the SPI output register; bits [7:0] are the byte to send.
REQ-006 spi_clkdiv  input  32  SHALL carry the SPI clock-divider register; bits [DIV_W-1:0] are used.
REQ-007 spi_rx_data  output  32  SHALL carry status and data to the SPI input register: [7:0] rx byte, [8] busy, [9] done, [10] overrun, [31:11] zero.
REQ-008 sclk  output  1  SHALL be the SPI serial clock, mode 0 (idle low).
REQ-009 mosi  output  1  SHALL be serial data out, MSB first.
REQ-010 miso  input  1  SHALL be serial data in.
REQ-011 cs_n  output  1  SHALL be the active-low chip select.

Function
REQ-012 H SHALL denote spi_clkdiv[DIV_W-1:0]+1 clk cycles, one SCLK half-period; value 0 gives H=1.
REQ-013 FSM states SHALL be IDLE, SETUP, SHIFT, HOLD.
REQ-014 In IDLE with spi_start=1 the block SHALL latch tx byte and divider, clear done and overrun, and enter SETUP next cycle.
REQ-015 SETUP SHALL last H cycles with cs_n=0, sclk=0, mosi=tx bit 7.
REQ-016 SHIFT SHALL last 16H cycles producing 8 SCLK pulses, high half first after SETUP.
REQ-017 On each sclk rising edge miso SHALL be sampled into the rx shift register LSB end.
REQ-018 On each sclk falling edge, except the last, mosi SHALL advance to the next lower tx bit.
REQ-019 HOLD SHALL last H cycles with sclk=0 and cs_n=0, then cs_n=1, rx byte updated, done=1, state IDLE.
REQ-020 busy SHALL be 1 in SETUP, SHIFT and HOLD, exactly 18H cycles starting the cycle after accepted spi_start.
REQ-021 spi_start while busy SHALL be ignored and SHALL set sticky overrun.
REQ-022 Changes to spi_tx_data or spi_clkdiv while busy SHALL NOT affect the current transfer.
REQ-023 rx byte SHALL hold its last completed value until the next transfer completes.
REQ-024 In IDLE cs_n SHALL be 1, sclk 0, mosi 0.

Reset
REQ-025 rst SHALL force IDLE, cs_n=1, sclk=0, mosi=0, spi_rx_data=0, counters cleared.
REQ-026 rst mid-transfer SHALL abort it in the same edge with no done, rx byte cleared to 0.
REQ-027 spi_start coincident with rst SHALL be ignored.

Configuration
REQ-028 With SPI_LOOPBACK_EN defined, the sampled input SHALL be the internal mosi and the miso port SHALL be ignored.
REQ-029 Without SPI_LOOPBACK_EN, the sampled input SHALL be the miso port.

Verification
REQ-030 clkdiv=0, tx=0xA5, miso driven from a slave model returning 0x3C -> mosi 1,0,1,0,0,1,0,1; rx byte 0x3C; busy exactly 18 cycles; done=1; cs_n=1.
REQ-031 clkdiv=3, tx=0x81 -> sclk high/low 4 cycles each, 8 pulses; busy 72 cycles.
REQ-032 spi_start again at cycle 5 of a clkdiv=0 transfer -> overrun=1, transfer unchanged, next accepted start clears overrun and done.
REQ-033 rst asserted at cycle 10 of a clkdiv=1 transfer -> next cycle cs_n=1, sclk=0, spi_rx_data=0, IDLE.
REQ-034 SPI_LOOPBACK_EN defined, miso held 0, tx=0x5A -> rx byte 0x5A.
REQ-035 spi_clkdiv changed 1->7 mid-transfer -> current transfer completes at H=2 timing; next uses H=8.
